// File: rtl/elevator_pkg.sv
// Shared types and the idle/door-exit scan decision for the elevator scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} car_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Pick a travel direction from the scan terms; ties go to the last direction served.
    function automatic car_state_t scan_decision(
        input logic any_above,
        input logic any_below,
        input logic last_dir
    );
        if (any_above && any_below) begin
            return (last_dir == DIR_UP) ? MOVE_UP : MOVE_DOWN;
        end else if (any_above) begin
            return MOVE_UP;
        end else if (any_below) begin
            return MOVE_DOWN;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/elevator_floor_scan.sv
// Reduces the pending bitmap into above/below/here terms relative to the car position.
module elevator_floor_scan #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    car_floor,
    output logic                  any_above,
    output logic                  any_below,
    output logic                  here
);

    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] below_mask;
    logic [NUM_FLOORS-1:0] here_mask;

    // Position masks built by comparison so no variable part-select is needed.
    always_comb begin
        above_mask = '0;
        below_mask = '0;
        here_mask  = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_mask[i] = FLOOR_W'(i) > car_floor;
            below_mask[i] = FLOOR_W'(i) < car_floor;
            here_mask[i]  = FLOOR_W'(i) == car_floor;
        end
    end

    assign any_above = |(pending & above_mask);
    assign any_below = |(pending & below_mask);
    assign here      = |(pending & here_mask);

endmodule

// File: rtl/elevator_scan_scheduler.sv
// LOOK-style elevator scheduler: request bitmap plus scan FSM driving motor and door commands.
module elevator_scan_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  logic                  floor_tick,
    input  logic                  door_done,
    output logic                  move_en,
    output logic                  next_up_ndown,
    output logic                  door_open,
    output logic                  queue_empty,
    output logic [NUM_FLOORS-1:0] pending
);

    car_state_t            state;
    car_state_t            state_nxt;
    logic                  last_dir;
    logic                  last_dir_nxt;
    logic                  any_above;
    logic                  any_below;
    logic                  here;
    logic                  req_in_range;
    logic                  door_entry;
    logic [NUM_FLOORS-1:0] set_vec;
    logic [NUM_FLOORS-1:0] clr_vec;
    logic [NUM_FLOORS-1:0] pending_nxt;

    elevator_floor_scan #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_floor_scan (
        .pending    (pending),
        .car_floor  (car_floor),
        .any_above  (any_above),
        .any_below  (any_below),
        .here       (here)
    );

    // Scan decisions; move states only re-evaluate on an alignment tick.
    always_comb begin
        state_nxt    = state;
        last_dir_nxt = last_dir;
        unique case (state)
            IDLE: begin
                state_nxt = here ? DOOR : scan_decision(any_above, any_below, last_dir);
            end
            MOVE_UP: begin
                if (floor_tick) begin
                    if (here)           state_nxt = DOOR;
                    else if (any_above) state_nxt = MOVE_UP;
                    else if (any_below) state_nxt = MOVE_DOWN;
                    else                state_nxt = IDLE;
                end
            end
            MOVE_DOWN: begin
                if (floor_tick) begin
                    if (here)           state_nxt = DOOR;
                    else if (any_below) state_nxt = MOVE_DOWN;
                    else if (any_above) state_nxt = MOVE_UP;
                    else                state_nxt = IDLE;
                end
            end
            DOOR: begin
                if (door_done) state_nxt = scan_decision(any_above, any_below, last_dir);
            end
            default: state_nxt = IDLE;
        endcase

        door_entry = (state_nxt == DOOR) && (state != DOOR);
        if (door_entry && (state == MOVE_UP))   last_dir_nxt = DIR_UP;
        if (door_entry && (state == MOVE_DOWN)) last_dir_nxt = DIR_DOWN;
    end

    // The served floor is cleared on door entry and held clear for the whole door cycle.
    always_comb begin
        req_in_range = 32'(req_floor) < NUM_FLOORS;
        set_vec      = (req_valid && req_in_range) ? (NUM_FLOORS'(1) << req_floor) : '0;
        clr_vec      = (door_entry || (state == DOOR)) ? (NUM_FLOORS'(1) << car_floor) : '0;
        pending_nxt  = (pending | set_vec) & ~clr_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_dir      <= DIR_UP;
            pending       <= '0;
            queue_empty   <= 1'b1;
            move_en       <= 1'b0;
            door_open     <= 1'b0;
            next_up_ndown <= DIR_UP;
        end else begin
            state       <= state_nxt;
            last_dir    <= last_dir_nxt;
            pending     <= pending_nxt;
            queue_empty <= ~|pending_nxt;
            move_en     <= (state_nxt == MOVE_UP) || (state_nxt == MOVE_DOWN);
            door_open   <= state_nxt == DOOR;
            if (state_nxt == MOVE_UP)   next_up_ndown <= DIR_UP;
            if (state_nxt == MOVE_DOWN) next_up_ndown <= DIR_DOWN;
        end
    end

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// Directed bench: 8-floor instance driven from a vector table, 5-floor instance by a hand sequence.
module tb_elevator_scan_scheduler;

    typedef struct {
        logic       rst;
        logic       rv;
        logic [2:0] rf;
        logic [2:0] cf;
        logic       tk;
        logic       dd;
        logic       me;
        logic       dir;
        logic       dop;
        logic       qe;
        logic [7:0] pend;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, req_valid, floor_tick, door_done;
    logic [2:0] req_floor, car_floor;
    logic       move_en, next_up_ndown, door_open, queue_empty;
    logic [7:0] pending;

    logic       rst5, req_valid5, floor_tick5, door_done5;
    logic [2:0] req_floor5, car_floor5;
    logic       move_en5, next_up_ndown5, door_open5, queue_empty5;
    logic [4:0] pending5;

    int checks   = 0;
    int failures = 0;
    vec_t vecs[$];

    elevator_scan_scheduler #(.NUM_FLOORS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_floor     (req_floor),
        .car_floor     (car_floor),
        .floor_tick    (floor_tick),
        .door_done     (door_done),
        .move_en       (move_en),
        .next_up_ndown (next_up_ndown),
        .door_open     (door_open),
        .queue_empty   (queue_empty),
        .pending       (pending)
    );

    elevator_scan_scheduler #(.NUM_FLOORS(5)) dut5 (
        .clk           (clk),
        .rst           (rst5),
        .req_valid     (req_valid5),
        .req_floor     (req_floor5),
        .car_floor     (car_floor5),
        .floor_tick    (floor_tick5),
        .door_done     (door_done5),
        .move_en       (move_en5),
        .next_up_ndown (next_up_ndown5),
        .door_open     (door_open5),
        .queue_empty   (queue_empty5),
        .pending       (pending5)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rst_i, input logic rv, input logic [2:0] rf,
                               input logic [2:0] cf, input logic tk, input logic dd,
                               input logic me, input logic dir, input logic dop,
                               input logic qe, input logic [7:0] pend);
        vec_t r;
        r.rst = rst_i; r.rv = rv; r.rf = rf; r.cf = cf; r.tk = tk; r.dd = dd;
        r.me = me; r.dir = dir; r.dop = dop; r.qe = qe; r.pend = pend;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check5(input string tag, input logic me, input logic dir, input logic dop,
                          input logic qe, input logic [4:0] pend);
        check({tag, " move_en"},       64'(move_en5),       64'(me));
        check({tag, " next_up_ndown"}, 64'(next_up_ndown5), 64'(dir));
        check({tag, " door_open"},     64'(door_open5),     64'(dop));
        check({tag, " queue_empty"},   64'(queue_empty5),   64'(qe));
        check({tag, " pending"},       64'(pending5),       64'(pend));
    endtask

    task automatic drive5(input logic rv, input logic [2:0] rf, input logic [2:0] cf,
                          input logic tk, input logic dd);
        req_valid5 = rv; req_floor5 = rf; car_floor5 = cf; floor_tick5 = tk; door_done5 = dd;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_floor = 3'd0; car_floor = 3'd2;
        floor_tick = 1'b0; door_done = 1'b0;
        rst5 = 1'b1;
        drive5(1'b0, 3'd0, 3'd2, 1'b0, 1'b0);

        //        rst rv rf  cf  tk dd   me dir dop qe pend
        vecs.push_back(v(0, 1, 5, 2, 0, 0,  0, 1, 0, 0, 8'h20));
        vecs.push_back(v(0, 0, 0, 2, 0, 0,  1, 1, 0, 0, 8'h20));
        vecs.push_back(v(0, 0, 0, 3, 1, 0,  1, 1, 0, 0, 8'h20));
        vecs.push_back(v(0, 0, 0, 4, 1, 0,  1, 1, 0, 0, 8'h20));
        vecs.push_back(v(0, 0, 0, 5, 1, 0,  0, 1, 1, 1, 8'h00));
        vecs.push_back(v(0, 0, 0, 5, 0, 1,  0, 1, 0, 1, 8'h00));
        vecs.push_back(v(0, 1, 6, 3, 0, 0,  0, 1, 0, 0, 8'h40));
        vecs.push_back(v(0, 1, 1, 3, 0, 0,  1, 1, 0, 0, 8'h42));
        vecs.push_back(v(0, 0, 0, 4, 1, 0,  1, 1, 0, 0, 8'h42));
        vecs.push_back(v(0, 0, 0, 5, 1, 0,  1, 1, 0, 0, 8'h42));
        vecs.push_back(v(0, 0, 0, 6, 1, 0,  0, 1, 1, 0, 8'h02));
        vecs.push_back(v(0, 0, 0, 6, 0, 1,  1, 0, 0, 0, 8'h02));
        vecs.push_back(v(0, 0, 0, 5, 1, 0,  1, 0, 0, 0, 8'h02));
        vecs.push_back(v(0, 0, 0, 4, 0, 0,  1, 0, 0, 0, 8'h02));
        vecs.push_back(v(0, 0, 0, 1, 1, 0,  0, 0, 1, 1, 8'h00));
        // last_dir is down here, so the two-sided choice must head down
        vecs.push_back(v(0, 1, 5, 1, 0, 0,  0, 0, 1, 0, 8'h20));
        vecs.push_back(v(0, 1, 0, 1, 0, 0,  0, 0, 1, 0, 8'h21));
        vecs.push_back(v(0, 0, 0, 1, 0, 1,  1, 0, 0, 0, 8'h21));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 8'h20));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 8'h20));
        vecs.push_back(v(0, 1, 4, 3, 1, 0,  1, 1, 0, 0, 8'h30));
        vecs.push_back(v(0, 0, 0, 4, 1, 0,  0, 1, 1, 0, 8'h20));
        vecs.push_back(v(0, 1, 4, 4, 0, 0,  0, 1, 1, 0, 8'h20));
        vecs.push_back(v(0, 1, 0, 4, 0, 0,  0, 1, 1, 0, 8'h21));
        vecs.push_back(v(0, 0, 0, 4, 0, 1,  1, 1, 0, 0, 8'h21));
        vecs.push_back(v(0, 0, 0, 5, 1, 0,  0, 1, 1, 0, 8'h01));
        vecs.push_back(v(0, 0, 0, 5, 0, 1,  1, 0, 0, 0, 8'h01));
        vecs.push_back(v(0, 1, 7, 5, 0, 0,  1, 0, 0, 0, 8'h81));
        vecs.push_back(v(0, 1, 6, 5, 0, 0,  1, 0, 0, 0, 8'hC1));
        vecs.push_back(v(1, 1, 3, 5, 0, 0,  0, 1, 0, 1, 8'h00));
        vecs.push_back(v(0, 0, 0, 5, 0, 0,  0, 1, 0, 1, 8'h00));
        vecs.push_back(v(0, 1, 5, 5, 0, 0,  0, 1, 0, 0, 8'h20));
        vecs.push_back(v(0, 0, 0, 5, 0, 0,  0, 1, 1, 1, 8'h00));
        vecs.push_back(v(0, 1, 2, 5, 0, 0,  0, 1, 1, 0, 8'h04));
        vecs.push_back(v(0, 1, 7, 5, 0, 0,  0, 1, 1, 0, 8'h84));
        vecs.push_back(v(0, 0, 0, 5, 0, 1,  1, 1, 0, 0, 8'h84));
        vecs.push_back(v(0, 0, 0, 6, 1, 0,  1, 1, 0, 0, 8'h84));
        vecs.push_back(v(0, 0, 0, 7, 1, 0,  0, 1, 1, 0, 8'h04));
        vecs.push_back(v(0, 0, 0, 7, 0, 1,  1, 0, 0, 0, 8'h04));
        vecs.push_back(v(0, 0, 0, 6, 1, 1,  1, 0, 0, 0, 8'h04));
        vecs.push_back(v(0, 0, 0, 2, 1, 0,  0, 0, 1, 1, 8'h00));
        vecs.push_back(v(0, 0, 0, 2, 1, 0,  0, 0, 1, 1, 8'h00));
        vecs.push_back(v(0, 0, 0, 2, 0, 1,  0, 0, 0, 1, 8'h00));

        step();
        check("reset move_en",       64'(move_en),       64'(0));
        check("reset next_up_ndown", 64'(next_up_ndown), 64'(1));
        check("reset door_open",     64'(door_open),     64'(0));
        check("reset queue_empty",   64'(queue_empty),   64'(1));
        check("reset pending",       64'(pending),       64'(0));

        rst = 1'b0;
        for (int c = 0; c < 10; c++) step();
        check("idle move_en",       64'(move_en),       64'(0));
        check("idle next_up_ndown", 64'(next_up_ndown), 64'(1));
        check("idle door_open",     64'(door_open),     64'(0));
        check("idle queue_empty",   64'(queue_empty),   64'(1));
        check("idle pending",       64'(pending),       64'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst        = vecs[i].rst;
            req_valid  = vecs[i].rv;
            req_floor  = vecs[i].rf;
            car_floor  = vecs[i].cf;
            floor_tick = vecs[i].tk;
            door_done  = vecs[i].dd;
            step();
            check($sformatf("row%0d move_en", i),       64'(move_en),       64'(vecs[i].me));
            check($sformatf("row%0d next_up_ndown", i), 64'(next_up_ndown), 64'(vecs[i].dir));
            check($sformatf("row%0d door_open", i),     64'(door_open),     64'(vecs[i].dop));
            check($sformatf("row%0d queue_empty", i),   64'(queue_empty),   64'(vecs[i].qe));
            check($sformatf("row%0d pending", i),       64'(pending),       64'(vecs[i].pend));
        end
        rst = 1'b0; req_valid = 1'b0; floor_tick = 1'b0; door_done = 1'b0;

        // Five-floor build: out-of-range drops and the top-floor reversal
        check5("n5 reset", 1'b0, 1'b1, 1'b0, 1'b1, 5'h00);
        rst5 = 1'b0;
        drive5(1'b1, 3'd7, 3'd2, 1'b0, 1'b0); step();
        check5("n5 drop7", 1'b0, 1'b1, 1'b0, 1'b1, 5'h00);
        drive5(1'b1, 3'd5, 3'd2, 1'b0, 1'b0); step();
        check5("n5 drop5", 1'b0, 1'b1, 1'b0, 1'b1, 5'h00);
        drive5(1'b1, 3'd3, 3'd2, 1'b0, 1'b0); step();
        check5("n5 req3", 1'b0, 1'b1, 1'b0, 1'b0, 5'h08);
        drive5(1'b1, 3'd0, 3'd2, 1'b0, 1'b0); step();
        check5("n5 up", 1'b1, 1'b1, 1'b0, 1'b0, 5'h09);
        drive5(1'b0, 3'd0, 3'd4, 1'b1, 1'b0); step();
        check5("n5 top_tick", 1'b1, 1'b0, 1'b0, 1'b0, 5'h09);
        drive5(1'b0, 3'd0, 3'd3, 1'b1, 1'b0); step();
        check5("n5 door3", 1'b0, 1'b0, 1'b1, 1'b0, 5'h01);
        drive5(1'b0, 3'd0, 3'd3, 1'b0, 1'b1); step();
        check5("n5 down", 1'b1, 1'b0, 1'b0, 1'b0, 5'h01);
        drive5(1'b0, 3'd0, 3'd0, 1'b1, 1'b0); step();
        check5("n5 door0", 1'b0, 1'b0, 1'b1, 1'b1, 5'h00);
        drive5(1'b1, 3'd4, 3'd0, 1'b0, 1'b0); step();
        check5("n5 req4", 1'b0, 1'b0, 1'b1, 1'b0, 5'h10);
        drive5(1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elevator_scan_scheduler.md
Name: elevator_scan_scheduler

Overview:
Parametrised, registered successor to the combinational direction resolver. It holds a pending-request bitmap for NUM_FLOORS floors and runs a LOOK-style scan FSM. The FSM commands the car to move up, move down, or stop with doors open, and clears each served request. It sits between the hall/cab request collectors and the car motor/door controllers.

Parameters:
NUM_FLOORS, 8, number of served floors; legal range 2..64.
FLOOR_W, $clog2(NUM_FLOORS), floor index width; derived, must not be overridden.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  one-cycle request strobe.
req_floor  in  FLOOR_W  floor being requested; qualified by req_valid.
car_floor  in  FLOOR_W  current car position from the position tracker.
floor_tick  in  1  one-cycle pulse when the car is aligned with car_floor.
door_done  in  1  one-cycle pulse from the door controller when the door cycle completes.
move_en  out  1  motor enable.
next_up_ndown  out  1  travel direction; 1 = up, 0 = down.
door_open  out  1  door-open command.
queue_empty  out  1  high when no request is pending.
pending  out  NUM_FLOORS  registered request bitmap; bit i = floor i.

Behaviour:
- Reset values: pending=0, state=IDLE, last_dir=1 (up), move_en=0, door_open=0, next_up_ndown=1, queue_empty=1.
- Request capture:
  - On req_valid with req_floor<NUM_FLOORS, pending[req_floor] is set at the next edge.
  - req_floor>=NUM_FLOORS is silently dropped.
  - A repeat request for an already-pending floor has no effect.
- Scan terms: any_above = |pending[NUM_FLOORS-1:car_floor+1]; any_below = |pending[car_floor-1:0]; here = pending[car_floor]. All are computed from registered pending, so a request takes at least 2 cycles to affect the FSM.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR. Outputs are registered and decoded from the state:
  - IDLE: move_en=0, door_open=0.
  - MOVE_UP / MOVE_DOWN: move_en=1; next_up_ndown = 1 / 0.
  - DOOR: door_open=1, move_en=0.
- IDLE transitions:
  - here -> DOOR.
  - Else any_above and any_below -> move in last_dir.
  - Else any_above -> MOVE_UP; any_below -> MOVE_DOWN.
  - Else stay in IDLE.
- MOVE_UP / MOVE_DOWN act only on the cycle floor_tick is high:
  - here -> DOOR.
  - Else a request ahead in the current direction -> stay.
  - Else a request behind -> opposite MOVE state.
  - Else -> IDLE.
- Floor boundaries: MOVE_UP at floor NUM_FLOORS-1 and MOVE_DOWN at floor 0 must never remain in the MOVE state after a floor_tick.
- DOOR:
  - On the entry edge, pending[car_floor] is cleared and last_dir records the direction of arrival. Entry from IDLE leaves last_dir unchanged.
  - While in DOOR, a request for car_floor is absorbed and never set.
  - On door_done, the IDLE decision rules are evaluated, except that here is ignored.
- Simultaneous events:
  - A clear for car_floor wins over a same-cycle req_valid for car_floor.
  - A set for any other floor always wins.
  - floor_tick or door_done in an inapplicable state is ignored.
- queue_empty = ~|pending, registered alongside pending.
- Reset asserted mid-move or mid-door returns the block to the reset values on the next edge and discards all pending requests.

Decomposition:
- elevator_pkg holds: typedef enum logic[1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} car_state_t; localparam DIR_UP=1'b1, DIR_DOWN=1'b0.
- One combinational sub-module, elevator_floor_scan (parameters NUM_FLOORS, FLOOR_W): inputs pending and car_floor; outputs any_above, any_below, here. It is implemented as masked reductions and has no variable part-selects.

Test Plan:
- Reset, then idle for 10 cycles -> pending=0, queue_empty=1, move_en=0, door_open=0, next_up_ndown=1.
- car_floor=2, request floor 5 -> MOVE_UP within 2 cycles. Ticks at floors 3 and 4 keep moving; tick at 5 -> DOOR, pending[5]=0. door_done -> IDLE, queue_empty=1.
- car_floor=3 in MOVE_UP with pending {6,1} -> serves 6, then reverses to MOVE_DOWN, serves 1. Verify last_dir drives the order when idle with requests on both sides.
- In DOOR at floor 4, inject req_floor=4 together with req_floor=0 -> pending[4] stays 0, pending[0]=1. door_done -> MOVE_DOWN.
- NUM_FLOORS=5 build: req_floor=7 ignored. MOVE_UP tick at floor 4 with only floor 0 pending -> MOVE_DOWN, never up.
- Assert rst during MOVE_DOWN with 3 floors pending -> next edge gives all outputs at reset values and pending=0.
